// File: rtl/fsm_lane_steerer.sv
// fsm_lane_steerer
//   Drives the transition-condition bus of an array of 4-state lane FSMs.
//   Each lane follows A->(c?B:C), B->(c?D:C), C->(c?A:D), D->(c?B:C).
//   A shadow copy of every lane runs in lock-step with the array.
//   On a request, the lanes are steered so that all of them reach their own
//   target on the same edge, exactly 4 edges after the request is accepted.
//
// Ports
//   clk          clock
//   rstn         asynchronous reset, active low (shared with the FSM array)
//   i_req        steering request, level, sampled only while o_busy=0
//   i_target     lane i target at [2i+1:2i]; A=0 B=1 C=2 D=3
//   o_cond       transition conditions to the FSM array
//   o_busy       steering sequence in progress
//   o_done       1-cycle pulse: every lane sits on its target this cycle
//   o_state      shadow state of every lane, same encoding as i_target
//
// Optional checker (define FSM_STEER_CHECK_EN)
//   i_obs_state  actual lane states reported by the FSM array
//   o_mismatch   sticky flag, set the edge after i_obs_state differs from
//                the shadow; cleared only by rstn
module fsm_lane_steerer #(
  parameter int P_NUM_FSM = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_req,
  input  logic [2*P_NUM_FSM-1:0] i_target,
  output logic [P_NUM_FSM-1:0]   o_cond,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [2*P_NUM_FSM-1:0] o_state
`ifdef FSM_STEER_CHECK_EN
  ,
  input  logic [2*P_NUM_FSM-1:0] i_obs_state,
  output logic                   o_mismatch
`endif
);

  localparam logic [1:0] ST_A = 2'd0;
  localparam logic [1:0] ST_B = 2'd1;
  localparam logic [1:0] ST_C = 2'd2;
  localparam logic [1:0] ST_D = 2'd3;

  // Steps from acceptance to rendezvous, stored minus one in step_cnt
  localparam logic [1:0] LAST_STEP = 2'd3;

  logic [2*P_NUM_FSM-1:0] shadow_q;
  logic [2*P_NUM_FSM-1:0] tgt_q;
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             step_cnt;

  // Lane transition table shared by the shadow and the steering lookahead
  function automatic logic [1:0] next_state(input logic [1:0] s, input logic c);
    logic [1:0] n;
    n = ST_C;
    case (s)
      ST_A:    n = c ? ST_B : ST_C;
      ST_B:    n = c ? ST_D : ST_C;
      ST_C:    n = c ? ST_A : ST_D;
      default: n = c ? ST_B : ST_C;
    endcase
    return n;
  endfunction

  // Set of states reachable from s in exactly k edges, one bit per state
  function automatic logic [3:0] reach_mask(input logic [1:0] k, input logic [1:0] s);
    logic [3:0] m;
    m = 4'b0000;
    case (k)
      2'd0: m = 4'b0001 << s;
      2'd1: case (s)
              ST_A:    m = 4'b0110;
              ST_B:    m = 4'b1100;
              ST_C:    m = 4'b1001;
              default: m = 4'b0110;
            endcase
      2'd2: case (s)
              ST_A:    m = 4'b1101;
              ST_B:    m = 4'b1111;
              ST_C:    m = 4'b0110;
              default: m = 4'b1101;
            endcase
      default: case (s)
              ST_C:    m = 4'b1101;
              default: m = 4'b1111;
            endcase
    endcase
    return m;
  endfunction

  // Take the 0 branch whenever the target stays reachable in the edges left
  // after this one; otherwise the 1 branch is the only way to still make it
  function automatic logic steer_cond(input logic [1:0] k, input logic [1:0] s,
                                      input logic [1:0] t);
    logic [3:0] m;
    m = reach_mask(k, next_state(s, 1'b0));
    return ~m[t];
  endfunction

  // Conditions depend on registers only, so no input reaches o_cond
  // combinationally; outside a sequence the array is left on the 0 branch
  always_comb begin
    o_cond = '0;
    if (busy_q) begin
      for (int i = 0; i < P_NUM_FSM; i++) begin
        o_cond[i] = steer_cond(step_cnt, shadow_q[2*i +: 2], tgt_q[2*i +: 2]);
      end
    end
  end

  // Shadow lanes follow the array every edge; the control part accepts a
  // request only when idle, counts down the four steering edges and raises
  // o_done for the cycle where every lane sits on its target
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      tgt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      step_cnt <= '0;
    end else begin
      for (int i = 0; i < P_NUM_FSM; i++) begin
        shadow_q[2*i +: 2] <= next_state(shadow_q[2*i +: 2], o_cond[i]);
      end
      done_q <= 1'b0;
      if (!busy_q) begin
        if (i_req) begin
          tgt_q    <= i_target;
          busy_q   <= 1'b1;
          step_cnt <= LAST_STEP;
        end
      end else if (step_cnt == 2'd0) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end else begin
        step_cnt <= step_cnt - 2'd1;
      end
    end
  end

  assign o_state = shadow_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

`ifdef FSM_STEER_CHECK_EN
  // Sticky divergence flag between the real array and the shadow copy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_mismatch <= 1'b0;
    end else if (i_obs_state != shadow_q) begin
      o_mismatch <= 1'b1;
    end
  end
`endif

  // The rendezvous promise: in the o_done cycle every lane equals its target
  a_rendezvous : assert property (@(posedge clk) disable iff (!rstn)
                                  done_q |-> (shadow_q == tgt_q));

endmodule

// File: tb/tb_fsm_lane_steerer.sv
// tb_fsm_lane_steerer
//   Self-checking bench for fsm_lane_steerer (P_NUM_FSM = 8).
//   A directed vector table, hand-written multi-cycle sequences and random
//   traffic are compared against a lane-level reference model that decides
//   each condition bit by exhaustive search over condition sequences.
module tb_fsm_lane_steerer;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           i_req = 1'b0;
  logic [2*N-1:0] i_target = '0;
  logic [N-1:0]   o_cond;
  logic           o_busy;
  logic           o_done;
  logic [2*N-1:0] o_state;
`ifdef FSM_STEER_CHECK_EN
  logic [2*N-1:0] obs_flip = '0;
  logic [2*N-1:0] i_obs_state;
  logic           o_mismatch;
  assign i_obs_state = o_state ^ obs_flip;
`endif

  fsm_lane_steerer #(.P_NUM_FSM(N)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_req       (i_req),
    .i_target    (i_target),
    .o_cond      (o_cond),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_state     (o_state)
`ifdef FSM_STEER_CHECK_EN
    ,
    .i_obs_state (i_obs_state),
    .o_mismatch  (o_mismatch)
`endif
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: lane states as integers, next-state as lookup tables
  int nxt0[4] = '{2, 2, 3, 2};
  int nxt1[4] = '{1, 3, 0, 1};
  int m_shadow[N];
  int m_tgt[N];
  bit m_busy;
  int m_left;
  bit m_done;

  function automatic bit can_reach(int s, int t, int k);
    int cur;
    for (int seq = 0; seq < (1 << k); seq++) begin
      cur = s;
      for (int j = 0; j < k; j++) cur = ((seq >> j) & 1) ? nxt1[cur] : nxt0[cur];
      if (cur == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [N-1:0] model_cond();
    logic [N-1:0] c;
    c = '0;
    if (m_busy)
      for (int i = 0; i < N; i++)
        c[i] = !can_reach(nxt0[m_shadow[i]], m_tgt[i], m_left - 1);
    return c;
  endfunction

  function automatic logic [2*N-1:0] model_state();
    logic [2*N-1:0] v;
    for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_shadow[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = 0;
      m_tgt[i] = 0;
    end
    m_busy = 0;
    m_left = 0;
    m_done = 0;
  endtask

  task automatic model_edge(input bit req, input logic [2*N-1:0] tgt);
    logic [N-1:0] c;
    c = model_cond();
    for (int i = 0; i < N; i++) m_shadow[i] = c[i] ? nxt1[m_shadow[i]] : nxt0[m_shadow[i]];
    m_done = 0;
    if (!m_busy) begin
      if (req) begin
        for (int i = 0; i < N; i++) m_tgt[i] = int'(tgt[2*i +: 2]);
        m_busy = 1;
        m_left = 4;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check_val("o_cond",  32'(o_cond),  32'(model_cond()));
    check_val("o_busy",  32'(o_busy),  32'(m_busy));
    check_val("o_done",  32'(o_done),  32'(m_done));
    check_val("o_state", 32'(o_state), 32'(model_state()));
  endtask

  // Called at a falling edge: drive, let one rising edge pass, then compare
  task automatic applyStimulus(input bit req, input logic [2*N-1:0] tgt);
    i_req = req;
    i_target = tgt;
    @(posedge clk);
    model_edge(req, tgt);
    @(negedge clk);
    checkOutput();
  endtask

  // Asynchronous reset pulse away from the rising edge; outputs must clear
  // before any clock edge arrives
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    check_val("rst_cond",  32'(o_cond),  32'd0);
    check_val("rst_busy",  32'(o_busy),  32'd0);
    check_val("rst_done",  32'(o_done),  32'd0);
    check_val("rst_state", 32'(o_state), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit          pre_reset;
    bit          req;
    logic [15:0] tgt;
    logic [7:0]  exp_cond;
    bit          exp_busy;
    bit          exp_done;
    logic [15:0] exp_state;
  } vec_t;

  vec_t vecs[9];
  logic [2*N-1:0] t1, t2;

  initial begin
    // Idle from reset: lanes walk A,C,D,C. Then lane0=B, lane1=D, rest A:
    // lane0 cond 0,0,0,1; lane1 cond 0,1,0,0; A lanes 0,1,0,1
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'hAAAA};
    vecs[1] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'hFFFF};
    vecs[2] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'hAAAA};
    vecs[3] = '{1'b1, 1'b1, 16'h000D, 8'h00, 1'b1, 1'b0, 16'hAAAA};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 8'hFE, 1'b1, 1'b0, 16'hFFFF};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h5556};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 8'hFD, 1'b1, 1'b0, 16'hAAAB};
    vecs[7] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 16'h000D};
    vecs[8] = '{1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'hAAAA};

    model_reset();
    @(negedge clk);
    for (int v = 0; v < 9; v++) begin
      if (vecs[v].pre_reset) do_reset();
      i_req = vecs[v].req;
      i_target = vecs[v].tgt;
      @(posedge clk);
      @(negedge clk);
      check_val($sformatf("vec%0d_cond", v),  32'(o_cond),  32'(vecs[v].exp_cond));
      check_val($sformatf("vec%0d_busy", v),  32'(o_busy),  32'(vecs[v].exp_busy));
      check_val($sformatf("vec%0d_done", v),  32'(o_done),  32'(vecs[v].exp_done));
      check_val($sformatf("vec%0d_state", v), 32'(o_state), 32'(vecs[v].exp_state));
    end

    // Request held high, target changed while busy, back-to-back requests
    do_reset();
    t1 = 16'h1B6C;
    t2 = 16'hE4D2;
    applyStimulus(1'b1, t1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, t2 ^ 16'(k));
    applyStimulus(1'b1, t2);
    check_val("hold_done_state", 32'(o_state), 32'(t1));
    check_val("hold_gap_busy", 32'(o_busy), 32'd0);
    applyStimulus(1'b1, t2);
    check_val("hold_reaccept_busy", 32'(o_busy), 32'd1);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0);
    check_val("hold_second_done", 32'(o_done), 32'd1);
    check_val("hold_second_state", 32'(o_state), 32'(t2));

    // Reset during step 2 aborts the sequence, then a fresh request works
    do_reset();
    applyStimulus(1'b1, t1);
    applyStimulus(1'b0, '0);
    do_reset();
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, '0);
    applyStimulus(1'b1, t2);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0);
    check_val("abort_then_done", 32'(o_done), 32'd1);
    check_val("abort_then_state", 32'(o_state), 32'(t2));

    // Random traffic against the model, with occasional resets
    do_reset();
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(99) == 0) do_reset();
      else applyStimulus($urandom_range(2) == 0, 16'($urandom));
    end

`ifdef FSM_STEER_CHECK_EN
    // One-cycle divergence on lane 3 makes the flag stick until reset
    do_reset();
    applyStimulus(1'b0, '0);
    check_val("mis_clear", 32'(o_mismatch), 32'd0);
    obs_flip = 16'h0040;
    applyStimulus(1'b0, '0);
    obs_flip = '0;
    check_val("mis_set", 32'(o_mismatch), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'($urandom));
    check_val("mis_sticky", 32'(o_mismatch), 32'd1);
    do_reset();
    check_val("mis_reset", 32'(o_mismatch), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
